// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds default widths for the fetch path, the return-address stack depth
// and the instruction word used for reset/bubble contents.
package cpu_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int INSTR_W_DEF   = 16;
  localparam int RAS_DEPTH_DEF = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a write pointer and a count.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, pop           push_data onto / remove the top entry (pop wins)
//   push_data           return address to save
//   top                 newest entry (content undefined while empty)
//   empty, full         occupancy status
//   overflow            sticky: a push hit a full stack
//   underflow           sticky: a pop hit an empty stack
module ras_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  // ptr addresses the next free slot; the newest entry sits just below it.
  // DEPTH is a power of two, so the pointer wraps on its own and a push
  // onto a full stack lands on the oldest entry.
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;
  logic [CNT_W-1:0]  count;

  assign top_idx = ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - CNT_W'(1);
      end
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full) overflow <= 1'b1;
      else      count    <= count + CNT_W'(1);
    end
  end

  // Entry storage carries no reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push && !pop) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: drives the instruction memory from the PC register,
// registers the returned word with its address, and selects the next PC
// (stall / return / call / branch / sequential) with a return-address stack.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   pc_in, pc_next           PC register output / input
//   imem_addr, imem_rdata    combinational instruction memory read
//   stall                    hold fetch, ignore redirects this cycle
//   branch_taken, call, ret  redirect requests for the word in instr
//   target                   branch/call destination
//   instr, instr_pc          fetched word and its address
//   instr_valid              0 marks a bubble / squashed fetch
//   ras_overflow/underflow   sticky stack error flags
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  logic              do_ret;
  logic              do_call;
  logic              do_branch;
  logic              redirect;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ret_addr;
  logic              ras_empty;
  logic              ras_full;

  assign imem_addr = pc_in;

  // Redirects only count for a live instruction; ret beats a simultaneous call.
  assign do_ret    = instr_valid & ret;
  assign do_call   = instr_valid & call & ~ret;
  assign do_branch = instr_valid & branch_taken;
  assign redirect  = do_ret | do_call | do_branch;

  assign ras_push  = ~stall & do_call;
  assign ras_pop   = ~stall & do_ret;
  assign ret_addr  = ras_empty ? '0 : ras_top;

  always_comb begin
    pc_next = pc_in + ADDR_W'(1);
    if (stall)                      pc_next = pc_in;
    else if (do_ret)                pc_next = ret_addr;
    else if (do_call || do_branch)  pc_next = target;
  end

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (instr_pc + ADDR_W'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Fetch register stage: the word fetched alongside a redirect is on the
  // wrong path, so it is captured but marked invalid (one bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= INSTR_W'(NOP_INSTR);
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr       <= imem_rdata;
      instr_pc    <= pc_in;
      instr_valid <= ~redirect;
    end
  end

  a_call_ret_exclusive : assert property (
    @(posedge clk) disable iff (reset) !(instr_valid && call && ret));

  a_push_full_flags : assert property (
    @(posedge clk) disable iff (reset) (ras_push && ras_full) |=> ras_overflow);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: closes the loop with a PC register and a
// combinational memory holding 16'hA000 + address, then applies a vector
// table, hand-written redirect/stack/stall/reset sequences and random
// traffic, comparing every cycle against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          stall, branch_taken, call, ret;
  logic [AW-1:0] target;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid, ras_overflow, ras_underflow;
  logic          ld_en;
  logic [AW-1:0] ld_val;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .RAS_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc),
    .pc_next       (pc_next),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .call          (call),
    .ret           (ret),
    .target        (target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // PC register outside the DUT, with a bench-side load to force pc_in.
  always @(posedge clk) begin
    if (reset)      pc <= '0;
    else if (ld_en) pc <= ld_val;
    else            pc <= pc_next;
  end

  assign imem_rdata = 16'hA000 + {8'h00, imem_addr};

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [IW-1:0] m_instr;
  logic [AW-1:0] m_ipc;
  logic          m_valid, m_ovf, m_unf;
  logic [AW-1:0] ras_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr = '0; m_ipc = '0; m_valid = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    ras_q.delete();
  endtask

  // One cycle: drive at negedge, compare at negedge+1, advance the model.
  task automatic step(input bit s, input bit b, input bit c, input bit r,
                      input logic [AW-1:0] t, input bit rst,
                      input bit ld, input logic [AW-1:0] lv);
    logic [AW-1:0] e_next;
    logic [AW-1:0] cur;
    bit            redir;
    @(negedge clk);
    stall = s; branch_taken = b; call = c; ret = r; target = t;
    reset = rst; ld_en = ld; ld_val = lv;
    #1;
    cur = pc;
    if (s)                    e_next = cur;
    else if (m_valid && r)    e_next = (ras_q.size() != 0) ? ras_q[$] : 8'h00;
    else if (m_valid && (c || b)) e_next = t;
    else                      e_next = cur + 8'd1;
    chk("imem_addr", imem_addr, cur);
    chk("pc_next", pc_next, e_next);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", instr_valid, m_valid);
    chk("ras_overflow", ras_overflow, m_ovf);
    chk("ras_underflow", ras_underflow, m_unf);
    if (rst) begin
      model_reset();
    end else if (!s) begin
      redir = m_valid && (r || c || b);
      if (m_valid && r) begin
        if (ras_q.size() == 0) m_unf = 1'b1;
        else void'(ras_q.pop_back());
      end else if (m_valid && c) begin
        if (ras_q.size() == D) begin
          void'(ras_q.pop_front());
          m_ovf = 1'b1;
        end
        ras_q.push_back(m_ipc + 8'd1);
      end
      m_instr = 16'hA000 + {8'h00, cur};
      m_ipc   = cur;
      m_valid = !redir;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  // Branch away from a live instruction and absorb the bubble.
  task automatic jump(input logic [AW-1:0] a);
    step(0, 1, 0, 0, a, 0, 0, 8'h00);
    idle();
  endtask

  typedef struct {
    bit            s, b, c, r;
    logic [AW-1:0] t;
    logic [AW-1:0] e_next;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_ipc;
    bit            e_v;
  } vec_t;

  vec_t tbl[11];
  logic [AW-1:0] ret_exp[5];

  initial begin
    tbl[0]  = '{0,0,0,0,8'h00, 8'h01, 16'h0000, 8'h00, 0};
    tbl[1]  = '{0,0,0,0,8'h00, 8'h02, 16'hA000, 8'h00, 1};
    tbl[2]  = '{0,0,0,0,8'h00, 8'h03, 16'hA001, 8'h01, 1};
    tbl[3]  = '{0,0,0,0,8'h00, 8'h04, 16'hA002, 8'h02, 1};
    tbl[4]  = '{0,0,0,0,8'h00, 8'h05, 16'hA003, 8'h03, 1};
    tbl[5]  = '{0,1,0,0,8'h40, 8'h40, 16'hA004, 8'h04, 1};
    tbl[6]  = '{0,0,0,0,8'h00, 8'h41, 16'hA005, 8'h05, 0};
    tbl[7]  = '{0,0,0,0,8'h00, 8'h42, 16'hA040, 8'h40, 1};
    tbl[8]  = '{0,1,0,0,8'h20, 8'h20, 16'hA041, 8'h41, 1};
    tbl[9]  = '{0,1,0,0,8'h77, 8'h21, 16'hA042, 8'h42, 0};
    tbl[10] = '{0,0,0,0,8'h00, 8'h22, 16'hA020, 8'h20, 1};
    ret_exp[0] = 8'h06; ret_exp[1] = 8'h05; ret_exp[2] = 8'h04;
    ret_exp[3] = 8'h03; ret_exp[4] = 8'h00;

    stall = 0; branch_taken = 0; call = 0; ret = 0; target = '0;
    ld_en = 0; ld_val = '0; reset = 1;
    repeat (2) @(posedge clk);
    model_reset();

    // Vector table: reset state, sequential fetch, branch, ignored branch
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].t, 0, 0, 8'h00);
      chk($sformatf("tbl%0d pc_next", i), pc_next, tbl[i].e_next);
      chk($sformatf("tbl%0d instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].e_ipc);
      chk($sformatf("tbl%0d valid", i), instr_valid, tbl[i].e_v);
    end

    // Call at 0x10 to 0x80, then return to 0x11
    jump(8'h10);
    step(0, 0, 1, 0, 8'h80, 0, 0, 8'h00);
    chk("call instr_pc", instr_pc, 8'h10);
    chk("call pc_next", pc_next, 8'h80);
    idle();
    chk("call bubble", instr_valid, 0);
    step(0, 0, 0, 1, 8'h00, 0, 0, 8'h00);
    chk("ret instr_pc", instr_pc, 8'h80);
    chk("ret pc_next", pc_next, 8'h11);
    idle();
    chk("ret bubble", instr_valid, 0);
    idle();
    chk("after ret instr_pc", instr_pc, 8'h11);
    chk("after ret valid", instr_valid, 1);
    chk("after ret ovf", ras_overflow, 0);
    chk("after ret unf", ras_underflow, 0);

    // Five nested calls into a four-deep stack, then five returns
    jump(8'h01);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1, 0, AW'(k + 1), 0, 0, 8'h00);
      chk($sformatf("nest call%0d instr_pc", k), instr_pc, k);
      idle();
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 8'h00, 0, 0, 8'h00);
      chk($sformatf("nest ret%0d pc_next", i), pc_next, ret_exp[i]);
      chk("nest ovf", ras_overflow, 1);
      idle();
    end
    chk("nest unf", ras_underflow, 1);

    // Stall with a branch request held: everything frozen
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 8'h55, 0, 0, 8'h00);
      chk("stall pc_next", pc_next, 8'h01);
      chk("stall instr", instr, 16'hA000);
      chk("stall instr_pc", instr_pc, 8'h00);
      chk("stall valid", instr_valid, 1);
    end
    step(0, 0, 0, 0, 8'h00, 0, 1, 8'hFF);
    idle();
    chk("wrap pc_in", pc, 8'hFF);
    chk("wrap pc_next", pc_next, 8'h00);
    chk("release no bubble", instr_valid, 1);

    // Reset with two return addresses on the stack
    jump(8'h30);
    step(0, 0, 1, 0, 8'h40, 0, 0, 8'h00);
    idle();
    step(0, 0, 1, 0, 8'h50, 0, 0, 8'h00);
    idle();
    chk("pre-reset ovf", ras_overflow, 1);
    step(0, 0, 0, 0, 8'h00, 1, 0, 8'h00);
    idle();
    chk("post-reset valid", instr_valid, 0);
    chk("post-reset ovf", ras_overflow, 0);
    chk("post-reset unf", ras_underflow, 0);
    step(0, 0, 0, 1, 8'h00, 0, 0, 8'h00);
    chk("post-reset ret pc_next", pc_next, 8'h00);
    idle();
    chk("post-reset unf set", ras_underflow, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int x;
      x = $urandom_range(0, 9);
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           (x == 0), (x == 1), AW'($urandom_range(0, 255)),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           AW'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
